// File: rtl/instr_encoder_loader_if.sv
// Request-beat stream into the loader and the instruction-memory write bus out of it.
// The loader side uses the slave modport; the driver of requests uses master.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_op_code;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_func3;
  logic              in_func7b5;
  logic [12:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_op_code, in_rd, in_rs1, in_rs2, in_func3, in_func7b5, in_imm, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_op_code, in_rd, in_rs1, in_rs2, in_func3, in_func7b5, in_imm, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs field-level instruction requests into RV32I words (R/I/S/B) and writes them to
// consecutive instruction-memory words, holding the core until a clean load completes.
module instr_encoder_loader #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  instr_encoder_loader_if.slave bus,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [ADDR_W:0]       count
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RALU  = 7'b0110011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [ADDR_W:0]   LAST_FREE = (ADDR_W+1)'((2**ADDR_W) - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              error_reg, error_next;
  logic [1:0]        code_reg, code_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;

  logic [31:0] word;
  logic        bad_op;
  logic        misaligned;
  logic        accept;

  always_comb begin
    word   = 32'h0;
    bad_op = 1'b0;
    case (bus.in_op_code)
      OP_LOAD, OP_IALU:
        word = {bus.in_imm[11:0], bus.in_rs1, bus.in_func3, bus.in_rd, bus.in_op_code};
      OP_STORE:
        word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_func3, bus.in_imm[4:0],
                bus.in_op_code};
      OP_RALU:
        word = {1'b0, bus.in_func7b5, 5'b00000, bus.in_rs2, bus.in_rs1, bus.in_func3, bus.in_rd,
                bus.in_op_code};
      OP_BR:
        word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_func3,
                bus.in_imm[4:1], bus.in_imm[11], bus.in_op_code};
      default:
        bad_op = 1'b1;
    endcase
  end

  assign misaligned = (bus.in_op_code == OP_BR) && bus.in_imm[0];
  // Capacity is exhausted once the MSB of count is set; the address can never wrap.
  assign bus.in_ready = (state_reg == S_LOAD) && !count_reg[ADDR_W];
  assign accept       = bus.in_valid && bus.in_ready && !start;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    error_next = error_reg;
    code_next  = code_reg;
    we_next    = 1'b0;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    if (start) begin
      state_next = S_LOAD;
      count_next = '0;
      error_next = 1'b0;
      code_next  = 2'b00;
      addr_next  = BASE;
    end else if (accept) begin
      if (bad_op || misaligned) begin
        // Beat is consumed without a write; only the first error of a session is recorded.
        if (!error_reg) begin
          error_next = 1'b1;
          code_next  = bad_op ? 2'b01 : 2'b11;
        end
        if (bus.in_last) state_next = S_DONE;
      end else begin
        we_next    = 1'b1;
        addr_next  = BASE + count_reg[ADDR_W-1:0];
        wdata_next = word;
        count_next = count_reg + 1'b1;
        if (bus.in_last) begin
          state_next = S_DONE;
        end else if (count_reg == LAST_FREE) begin
          state_next = S_DONE;
          if (!error_reg) begin
            error_next = 1'b1;
            code_next  = 2'b10;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      error_reg <= 1'b0;
      code_reg  <= 2'b00;
      we_reg    <= 1'b0;
      addr_reg  <= BASE;
      wdata_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      error_reg <= error_next;
      code_reg  <= code_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
    end
  end

  // A reset raised during the write cycle kills the strobe immediately.
  assign bus.imem_we    = we_reg && !reset;
  assign bus.imem_addr  = addr_reg;
  assign bus.imem_wdata = wdata_reg;
  assign done           = (state_reg == S_DONE);
  assign cpu_hold       = (state_reg != S_DONE) || error_reg;
  assign error          = error_reg;
  assign err_code       = code_reg;
  assign count          = count_reg;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed and randomized check of instr_encoder_loader against a cycle-level reference model.
module tb_instr_encoder_loader;
  localparam int AW  = 2;
  localparam int CAP = 4;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_hold, done, error;
  logic [1:0] err_code;
  logic [AW:0] count;

  always #5 clk = ~clk;

  instr_encoder_loader_if #(.ADDR_W(AW)) bus ();

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error),
    .err_code (err_code),
    .count    (count)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state: 0 idle, 1 loading, 2 done
  int          m_state;
  int          m_count;
  bit          m_err;
  int          m_code;
  bit          m_we;
  int          m_addr;
  int unsigned m_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_known_op(int unsigned op);
    return op == 'h03 || op == 'h13 || op == 'h23 || op == 'h33 || op == 'h63;
  endfunction

  // Field placement written directly from the RV32I format tables.
  function automatic int unsigned ref_enc(int unsigned op, int unsigned rd, int unsigned rs1,
                                          int unsigned rs2, int unsigned f3, int unsigned f7b5,
                                          int unsigned imm);
    int unsigned common;
    common = (rs1 << 15) | (f3 << 12) | op;
    case (op)
      'h03, 'h13: return ((imm & 'hFFF) << 20) | common | (rd << 7);
      'h23:       return (((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | common | ((imm & 'h1F) << 7);
      'h33:       return (f7b5 << 30) | (rs2 << 20) | common | (rd << 7);
      default:    return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20)
                         | common | (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7);
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_count = 0; m_err = 0; m_code = 0; m_we = 0; m_addr = 0; m_wdata = 0;
  endtask

  task automatic set_error(int code);
    if (!m_err) begin
      m_err  = 1;
      m_code = code;
    end
  endtask

  // Compare all outputs in the current cycle, advance the model, then step one clock.
  task automatic cycle();
    bit rdy;
    bit bad, mis;
    #1;
    rdy = (m_state == 1) && (m_count < CAP);
    check("in_ready", bus.in_ready, rdy);
    check("imem_we", bus.imem_we, m_we && !reset);
    if (m_we && !reset) begin
      check("imem_addr", bus.imem_addr, m_addr);
      check("imem_wdata", bus.imem_wdata, m_wdata);
    end
    check("count", count, m_count);
    check("done", done, m_state == 2);
    check("cpu_hold", cpu_hold, (m_state != 2) || m_err);
    check("error", error, m_err);
    check("err_code", err_code, m_code);

    if (reset) begin
      model_reset();
    end else if (start) begin
      m_state = 1; m_count = 0; m_err = 0; m_code = 0; m_we = 0; m_addr = 0;
    end else if (bus.in_valid && rdy) begin
      bad = !is_known_op(bus.in_op_code);
      mis = (bus.in_op_code == 7'h63) && bus.in_imm[0];
      if (bad || mis) begin
        m_we = 0;
        set_error(bad ? 1 : 3);
        if (bus.in_last) m_state = 2;
      end else begin
        m_we    = 1;
        m_addr  = m_count;
        m_wdata = ref_enc(bus.in_op_code, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_func3,
                          bus.in_func7b5, bus.in_imm);
        m_count++;
        $display("write addr=%0d data=%08h", m_addr, m_wdata);
        if (bus.in_last) begin
          m_state = 2;
        end else if (m_count == CAP) begin
          m_state = 2;
          set_error(2);
        end
      end
    end else begin
      m_we = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit [6:0] op, input bit [4:0] rd, input bit [4:0] rs1,
                       input bit [4:0] rs2, input bit [2:0] f3, input bit f7,
                       input bit [12:0] imm, input bit last);
    bus.in_valid   = v;
    bus.in_op_code = op;
    bus.in_rd      = rd;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_func3   = f3;
    bus.in_func7b5 = f7;
    bus.in_imm     = imm;
    bus.in_last    = last;
  endtask

  task automatic beat(input bit [6:0] op, input bit [4:0] rd, input bit [4:0] rs1,
                      input bit [4:0] rs2, input bit [2:0] f3, input bit f7,
                      input bit [12:0] imm, input bit last);
    drive(1'b1, op, rd, rs1, rs2, f3, f7, imm, last);
    cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    bit [6:0] bad_ops [5] = '{7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
    bit [6:0] good_ops [5] = '{7'h03, 7'h13, 7'h23, 7'h33, 7'h63};
    bit [6:0] op;
    bit [12:0] imm;

    reset = 1'b1;
    start = 1'b0;
    drive(1'b0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_addr", bus.imem_addr, 0);
    check("rst_wdata", bus.imem_wdata, 0);
    cycle();
    reset = 1'b0;
    cycle();

    // add x3,x1,x2
    do_start();
    beat(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 13'h0, 1'b1);
    check("t1_wdata", bus.imem_wdata, 32'h002081B3);
    check("t1_addr", bus.imem_addr, 0);
    check("t1_hold", cpu_hold, 0);
    check("t1_count", count, 1);
    cycle();

    // sub x3,x1,x2 ; lw x5,8(x2)
    do_start();
    beat(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 13'h0, 1'b0);
    check("t2_sub", bus.imem_wdata, 32'h402081B3);
    beat(7'h03, 5'd5, 5'd2, 5'd0, 3'd2, 1'b0, 13'd8, 1'b1);
    check("t2_lw", bus.imem_wdata, 32'h00812283);
    check("t2_addr", bus.imem_addr, 1);

    // sw x5,-4(x2) ; beq x1,x2,-8
    do_start();
    beat(7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 1'b0, 13'h1FFC, 1'b0);
    check("t3_sw", bus.imem_wdata, 32'hFE512E23);
    beat(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'h1FF8, 1'b1);
    check("t3_beq", bus.imem_wdata, 32'hFE208CE3);
    cycle();

    // unsupported opcode then a valid last beat
    do_start();
    beat(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 13'h10, 1'b0);
    beat(7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 13'h5, 1'b1);
    check("t4_addr", bus.imem_addr, 0);
    check("t4_code", err_code, 2'b01);
    check("t4_hold", cpu_hold, 1);
    cycle();

    // fill all words without last, then a refused fifth beat
    do_start();
    for (int i = 0; i < CAP; i++) beat(7'h33, 5'(i), 5'd1, 5'd2, 3'd0, 1'b0, 13'h0, 1'b0);
    check("t5_done", done, 1);
    check("t5_code", err_code, 2'b10);
    beat(7'h33, 5'd9, 5'd1, 5'd2, 3'd0, 1'b0, 13'h0, 1'b0);
    check("t5_count", count, CAP);

    // reset during the write cycle, then start mid-load
    do_start();
    beat(7'h13, 5'd4, 5'd4, 5'd0, 3'd0, 1'b0, 13'h7, 1'b0);
    reset = 1'b1;
    #1;
    check("t6_we_killed", bus.imem_we, 0);
    cycle();
    reset = 1'b0;
    do_start();
    beat(7'h13, 5'd4, 5'd4, 5'd0, 3'd0, 1'b0, 13'h7, 1'b0);
    beat(7'h13, 5'd4, 5'd4, 5'd0, 3'd0, 1'b0, 13'h8, 1'b0);
    start = 1'b1;
    beat(7'h13, 5'd4, 5'd4, 5'd0, 3'd0, 1'b0, 13'h9, 1'b0);
    start = 1'b0;
    beat(7'h13, 5'd4, 5'd4, 5'd0, 3'd0, 1'b0, 13'hA, 1'b0);
    check("t6_addr", bus.imem_addr, 0);
    check("t6_count", count, 1);

    for (int n = 0; n < 2500; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      start = (m_state != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0);
      op  = ($urandom_range(0, 9) == 0) ? bad_ops[$urandom_range(0, 4)]
                                        : good_ops[$urandom_range(0, 4)];
      imm = 13'($urandom);
      if (op == 7'h63 && $urandom_range(0, 5) != 0) imm[0] = 1'b0;
      drive($urandom_range(0, 3) != 0, op, 5'($urandom), 5'($urandom), 5'($urandom),
            3'($urandom), 1'($urandom), imm, $urandom_range(0, 4) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
